// File: rtl/memory_bus_arbiter.sv
// Two-master memory bus arbiter (instruction cache M0, data cache M1) with
// round-robin ties, outstanding-transfer limiting, ack flushing and timeout.
module memory_bus_arbiter #(
  parameter int TIMEOUT        = 255,
  parameter int MAXOUTSTANDING = 4
) (
  input  logic        Clock,
  input  logic        Reset,

  input  logic        M0Cycle,
  input  logic        M0Strobe,
  input  logic        M0ReadWrite,
  input  logic [1:0]  M0DataWidth,
  input  logic [31:0] M0Address,
  input  logic [31:0] M0DataIn,
  output logic        M0Acknowledge,
  output logic        M0Stall,
  output logic [31:0] M0DataOut,

  input  logic        M1Cycle,
  input  logic        M1Strobe,
  input  logic        M1ReadWrite,
  input  logic [1:0]  M1DataWidth,
  input  logic [31:0] M1Address,
  input  logic [31:0] M1DataIn,
  output logic        M1Acknowledge,
  output logic        M1Stall,
  output logic [31:0] M1DataOut,

  output logic        MemoryBusCycle,
  output logic        MemoryBusStrobe,
  output logic        MemoryBusReadWrite,
  output logic [1:0]  MemoryDataWidth,
  output logic [31:0] MemoryAddress,
  output logic [31:0] MemoryDataIn,
  input  logic [31:0] MemoryDataOut,
  input  logic        MemoryBusAcknowledge,
  input  logic        MemoryBusStall,

  output logic        BusError,
  output logic [1:0]  Grant
);

  localparam int OutW  = $clog2(MAXOUTSTANDING + 1);
  localparam int TimeW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, FLUSH} arbStateT;

  arbStateT              state, nextState;
  logic [OutW-1:0]       outstanding;
  logic [TimeW-1:0]      timeoutCount;
  logic                  lastGranted;   // 0 = M0, 1 = M1
  logic                  busErrorReg;

  logic                  full;
  logic                  accepted;
  logic                  ackValid;
  logic                  counting;
  logic                  timeoutHit;
  logic                  enteringGrant;

  assign full          = (outstanding == OutW'(MAXOUTSTANDING));
  assign accepted      = MemoryBusStrobe & ~MemoryBusStall;
  assign ackValid      = MemoryBusAcknowledge & (outstanding != '0);
  assign counting      = (state != IDLE) && (outstanding != '0);
  assign timeoutHit    = counting && !MemoryBusAcknowledge &&
                         (timeoutCount == TimeW'(TIMEOUT - 1));
  assign enteringGrant = ((nextState == GRANT0) || (nextState == GRANT1)) &&
                         (nextState != state);
  assign BusError      = busErrorReg;

  // Bus routing: only the granted master is connected; everyone else is held off.
  always_comb begin
    Grant              = 2'b00;
    MemoryBusCycle     = 1'b0;
    MemoryBusStrobe    = 1'b0;
    MemoryBusReadWrite = 1'b0;
    MemoryDataWidth    = '0;
    MemoryAddress      = '0;
    MemoryDataIn       = '0;
    M0Acknowledge      = 1'b0;
    M0Stall            = 1'b1;
    M0DataOut          = '0;
    M1Acknowledge      = 1'b0;
    M1Stall            = 1'b1;
    M1DataOut          = '0;
    case (state)
      GRANT0: begin
        Grant              = 2'b01;
        MemoryBusCycle     = M0Cycle;
        MemoryBusStrobe    = M0Strobe & ~full;
        MemoryBusReadWrite = M0ReadWrite;
        MemoryDataWidth    = M0DataWidth;
        MemoryAddress      = M0Address;
        MemoryDataIn       = M0DataIn;
        M0Acknowledge      = MemoryBusAcknowledge;
        M0Stall            = MemoryBusStall | full;
        M0DataOut          = MemoryDataOut;
      end
      GRANT1: begin
        Grant              = 2'b10;
        MemoryBusCycle     = M1Cycle;
        MemoryBusStrobe    = M1Strobe & ~full;
        MemoryBusReadWrite = M1ReadWrite;
        MemoryDataWidth    = M1DataWidth;
        MemoryAddress      = M1Address;
        MemoryDataIn       = M1DataIn;
        M1Acknowledge      = MemoryBusAcknowledge;
        M1Stall            = MemoryBusStall | full;
        M1DataOut          = MemoryDataOut;
      end
      default: ;
    endcase
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (M0Cycle && M1Cycle) nextState = lastGranted ? GRANT0 : GRANT1;
        else if (M0Cycle)       nextState = GRANT0;
        else if (M1Cycle)       nextState = GRANT1;
      end
      GRANT0: begin
        if (!M0Cycle) begin
          if (outstanding == '0) nextState = M1Cycle ? GRANT1 : IDLE;
          else                   nextState = FLUSH;
        end
      end
      GRANT1: begin
        if (!M1Cycle) begin
          if (outstanding == '0) nextState = M0Cycle ? GRANT0 : IDLE;
          else                   nextState = FLUSH;
        end
      end
      FLUSH: begin
        // lastGranted still names the master whose transfers are being drained
        if (outstanding == '0) begin
          if (lastGranted) nextState = M0Cycle ? GRANT0 : IDLE;
          else             nextState = M1Cycle ? GRANT1 : IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
    if (timeoutHit) nextState = IDLE;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      outstanding  <= '0;
      timeoutCount <= '0;
      lastGranted  <= 1'b1;
      busErrorReg  <= 1'b0;
    end else begin
      state       <= nextState;
      busErrorReg <= timeoutHit;

      if (timeoutHit || enteringGrant) begin
        outstanding <= '0;
      end else begin
        case ({accepted, ackValid})
          2'b10:   outstanding <= outstanding + OutW'(1);
          2'b01:   outstanding <= outstanding - OutW'(1);
          default: outstanding <= outstanding;
        endcase
      end

      if (timeoutHit || (nextState != state) || MemoryBusAcknowledge)
        timeoutCount <= '0;
      else if (counting)
        timeoutCount <= timeoutCount + TimeW'(1);

      if (enteringGrant) lastGranted <= (nextState == GRANT1);
    end
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level ownership model.
module tb_memory_bus_arbiter;

  localparam int TOUT   = 8;
  localparam int MAXOUT = 4;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        M0Cycle, M0Strobe, M0ReadWrite;
  logic [1:0]  M0DataWidth;
  logic [31:0] M0Address, M0DataIn, M0DataOut;
  logic        M0Acknowledge, M0Stall;
  logic        M1Cycle, M1Strobe, M1ReadWrite;
  logic [1:0]  M1DataWidth;
  logic [31:0] M1Address, M1DataIn, M1DataOut;
  logic        M1Acknowledge, M1Stall;
  logic        MemoryBusCycle, MemoryBusStrobe, MemoryBusReadWrite;
  logic [1:0]  MemoryDataWidth;
  logic [31:0] MemoryAddress, MemoryDataIn, MemoryDataOut;
  logic        MemoryBusAcknowledge, MemoryBusStall;
  logic        BusError;
  logic [1:0]  Grant;

  int errors = 0;
  int checks = 0;

  // model state: owner -1 none / 0 / 1, draining flag, pending count, wait count
  int mOwn, mPend, mWait, mLast;
  bit mFlush, mBusErr;

  memory_bus_arbiter #(.TIMEOUT(TOUT), .MAXOUTSTANDING(MAXOUT)) dut (
    .Clock(Clock), .Reset(Reset),
    .M0Cycle(M0Cycle), .M0Strobe(M0Strobe), .M0ReadWrite(M0ReadWrite),
    .M0DataWidth(M0DataWidth), .M0Address(M0Address), .M0DataIn(M0DataIn),
    .M0Acknowledge(M0Acknowledge), .M0Stall(M0Stall), .M0DataOut(M0DataOut),
    .M1Cycle(M1Cycle), .M1Strobe(M1Strobe), .M1ReadWrite(M1ReadWrite),
    .M1DataWidth(M1DataWidth), .M1Address(M1Address), .M1DataIn(M1DataIn),
    .M1Acknowledge(M1Acknowledge), .M1Stall(M1Stall), .M1DataOut(M1DataOut),
    .MemoryBusCycle(MemoryBusCycle), .MemoryBusStrobe(MemoryBusStrobe),
    .MemoryBusReadWrite(MemoryBusReadWrite), .MemoryDataWidth(MemoryDataWidth),
    .MemoryAddress(MemoryAddress), .MemoryDataIn(MemoryDataIn),
    .MemoryDataOut(MemoryDataOut), .MemoryBusAcknowledge(MemoryBusAcknowledge),
    .MemoryBusStall(MemoryBusStall), .BusError(BusError), .Grant(Grant)
  );

  always #5 Clock = ~Clock;

  task automatic nextCycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic clearInputs();
    M0Cycle = 0; M0Strobe = 0; M0ReadWrite = 0; M0DataWidth = 0; M0Address = 0; M0DataIn = 0;
    M1Cycle = 0; M1Strobe = 0; M1ReadWrite = 0; M1DataWidth = 0; M1Address = 0; M1DataIn = 0;
    MemoryDataOut = 0; MemoryBusAcknowledge = 0; MemoryBusStall = 0;
  endtask

  task automatic applyReset();
    clearInputs();
    Reset = 0;
    @(posedge Clock);
    @(posedge Clock);
    #1;
    Reset = 1;
  endtask

  function automatic bit cycOf(int m);
    return (m == 0) ? M0Cycle : M1Cycle;
  endfunction

  function automatic logic [139:0] modelOutputs();
    int g;
    bit full;
    logic [1:0] gr;
    logic a0, s0, a1, s1, mc, ms, mrw;
    logic [31:0] d0, d1, ma, mdi;
    logic [1:0] mw;
    g = (mOwn >= 0 && !mFlush) ? mOwn : -1;
    full = (g >= 0) && (mPend == MAXOUT);
    gr = 2'b00; a0 = 0; s0 = 1; d0 = 0; a1 = 0; s1 = 1; d1 = 0;
    mc = 0; ms = 0; mrw = 0; mw = 0; ma = 0; mdi = 0;
    if (g == 0) begin
      gr = 2'b01; a0 = MemoryBusAcknowledge; s0 = MemoryBusStall | full; d0 = MemoryDataOut;
      mc = M0Cycle; ms = M0Strobe & !full; mrw = M0ReadWrite; mw = M0DataWidth;
      ma = M0Address; mdi = M0DataIn;
    end else if (g == 1) begin
      gr = 2'b10; a1 = MemoryBusAcknowledge; s1 = MemoryBusStall | full; d1 = MemoryDataOut;
      mc = M1Cycle; ms = M1Strobe & !full; mrw = M1ReadWrite; mw = M1DataWidth;
      ma = M1Address; mdi = M1DataIn;
    end
    return {gr, mBusErr, a0, s0, d0, a1, s1, d1, mc, ms, mrw, mw, ma, mdi};
  endfunction

  task automatic modelReset();
    mOwn = -1; mFlush = 0; mPend = 0; mWait = 0; mLast = 1; mBusErr = 0;
  endtask

  // advance the model across one clock edge using the inputs currently driven
  task automatic modelStep();
    int g, nOwn, newPend;
    bit nFlush, acc, changed, strobe;
    g = (mOwn >= 0 && !mFlush) ? mOwn : -1;
    strobe = (g == 0) ? M0Strobe : (g == 1) ? M1Strobe : 1'b0;
    acc = (g >= 0) && strobe && (mPend < MAXOUT) && !MemoryBusStall;
    if (mOwn >= 0 && mPend > 0 && !MemoryBusAcknowledge && mWait == TOUT - 1) begin
      mOwn = -1; mFlush = 0; mPend = 0; mWait = 0; mBusErr = 1;
      return;
    end
    mBusErr = 0;
    nOwn = mOwn; nFlush = mFlush;
    if (mOwn < 0) begin
      if (M0Cycle && M1Cycle) nOwn = 1 - mLast;
      else if (M0Cycle)       nOwn = 0;
      else if (M1Cycle)       nOwn = 1;
    end else if (!mFlush) begin
      if (!cycOf(mOwn)) begin
        if (mPend == 0) nOwn = cycOf(1 - mOwn) ? 1 - mOwn : -1;
        else            nFlush = 1;
      end
    end else if (mPend == 0) begin
      nFlush = 0;
      nOwn = cycOf(1 - mOwn) ? 1 - mOwn : -1;
    end
    changed = (nOwn != mOwn) || (nFlush != mFlush);
    if (changed || MemoryBusAcknowledge) mWait = 0;
    else if (mOwn >= 0 && mPend > 0)     mWait++;
    newPend = mPend + int'(acc) - int'(MemoryBusAcknowledge && mPend > 0);
    if (changed && nOwn >= 0 && !nFlush) begin
      newPend = 0;
      mLast = nOwn;
    end
    mPend = newPend; mOwn = nOwn; mFlush = nFlush;
  endtask

  task automatic test_reset();
    clearInputs();
    M0Cycle = 1; M0Strobe = 1; M1Cycle = 1; M1Strobe = 1; M0Address = 32'h55;
    MemoryBusAcknowledge = 1; MemoryDataOut = 32'hFFFF_0000;
    Reset = 0;
    #1;
    checks++; if (Grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", Grant); end
    checks++; if (BusError !== 1'b0) begin errors++; $display("FAIL reset_buserror got %b want 0", BusError); end
    checks++; if ({M0Stall, M1Stall} !== 2'b11) begin errors++; $display("FAIL reset_stall got %b want 11", {M0Stall, M1Stall}); end
    checks++; if ({M0Acknowledge, M1Acknowledge, M0DataOut, M1DataOut} !== '0) begin errors++;
      $display("FAIL reset_master_out got %b/%b/%h/%h want 0", M0Acknowledge, M1Acknowledge, M0DataOut, M1DataOut); end
    checks++; if ({MemoryBusCycle, MemoryBusStrobe, MemoryBusReadWrite, MemoryDataWidth, MemoryAddress, MemoryDataIn} !== '0) begin errors++;
      $display("FAIL reset_mem_out got cyc=%b stb=%b addr=%h want 0", MemoryBusCycle, MemoryBusStrobe, MemoryAddress); end
    applyReset();
  endtask

  task automatic test_single_read();
    applyReset();
    M0Cycle = 1; M0Strobe = 1; M0ReadWrite = 0; M0DataWidth = 2'd2; M0Address = 32'h100;
    #1;
    checks++; if (Grant !== 2'b00) begin errors++; $display("FAIL v1_no_comb_grant got %b want 00", Grant); end
    nextCycle();
    checks++; if (Grant !== 2'b01) begin errors++; $display("FAIL v1_grant got %b want 01", Grant); end
    checks++; if (MemoryAddress !== 32'h100 || MemoryBusStrobe !== 1'b1 || MemoryDataWidth !== 2'd2) begin errors++;
      $display("FAIL v1_mem_route got addr=%h stb=%b w=%0d want 100/1/2", MemoryAddress, MemoryBusStrobe, MemoryDataWidth); end
    checks++; if (M1Stall !== 1'b1) begin errors++; $display("FAIL v1_m1stall_a got %b want 1", M1Stall); end
    nextCycle();
    M0Strobe = 0; MemoryBusAcknowledge = 1; MemoryDataOut = 32'hDEAD_BEEF;
    #1;
    checks++; if (M0Acknowledge !== 1'b1 || M0DataOut !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL v1_ack got ack=%b data=%h want 1/deadbeef", M0Acknowledge, M0DataOut); end
    checks++; if (M1Acknowledge !== 1'b0 || M1DataOut !== 32'h0 || M1Stall !== 1'b1) begin errors++;
      $display("FAIL v1_m1_isolated got ack=%b data=%h stall=%b want 0/0/1", M1Acknowledge, M1DataOut, M1Stall); end
    nextCycle();
    MemoryBusAcknowledge = 0; M0Cycle = 0;
    #1;
    checks++; if (Grant !== 2'b01) begin errors++; $display("FAIL v1_hold got %b want 01", Grant); end
    nextCycle();
    checks++; if (Grant !== 2'b00) begin errors++; $display("FAIL v1_release got %b want 00", Grant); end
  endtask

  task automatic test_handover();
    applyReset();
    M0Cycle = 1; M1Cycle = 1;
    nextCycle();
    checks++; if (Grant !== 2'b01) begin errors++; $display("FAIL v2_first_tie got %b want 01", Grant); end
    M0Cycle = 0;
    nextCycle();
    checks++; if (Grant !== 2'b10) begin errors++; $display("FAIL v2_handover got %b want 10", Grant); end
    M1Cycle = 0;
    nextCycle();
    checks++; if (Grant !== 2'b00) begin errors++; $display("FAIL v2_idle got %b want 00", Grant); end
  endtask

  task automatic test_stall_limit();
    applyReset();
    M1Cycle = 1; M1Strobe = 1; M1ReadWrite = 1; M1Address = 32'h2000; M1DataIn = 32'h1234_5678;
    nextCycle();
    checks++; if (Grant !== 2'b10) begin errors++; $display("FAIL v3_grant got %b want 10", Grant); end
    for (int i = 0; i < MAXOUT; i++) begin
      checks++; if (MemoryBusStrobe !== 1'b1 || M1Stall !== 1'b0) begin errors++;
        $display("FAIL v3_accept%0d got stb=%b stall=%b want 1/0", i, MemoryBusStrobe, M1Stall); end
      nextCycle();
    end
    checks++; if (M1Stall !== 1'b1 || MemoryBusStrobe !== 1'b0 || MemoryBusCycle !== 1'b1) begin errors++;
      $display("FAIL v3_full got stall=%b stb=%b cyc=%b want 1/0/1", M1Stall, MemoryBusStrobe, MemoryBusCycle); end
    MemoryBusAcknowledge = 1;
    #1;
    checks++; if (M1Acknowledge !== 1'b1) begin errors++; $display("FAIL v3_ack got %b want 1", M1Acknowledge); end
    nextCycle();
    MemoryBusAcknowledge = 0;
    #1;
    checks++; if (M1Stall !== 1'b0 || MemoryBusStrobe !== 1'b1) begin errors++;
      $display("FAIL v3_unstall got stall=%b stb=%b want 0/1", M1Stall, MemoryBusStrobe); end
  endtask

  task automatic test_flush();
    applyReset();
    M0Cycle = 1; M0Strobe = 1; M0Address = 32'h40;
    nextCycle();
    checks++; if (Grant !== 2'b01) begin errors++; $display("FAIL v4_grant got %b want 01", Grant); end
    nextCycle();
    nextCycle();
    M0Strobe = 0; M0Cycle = 0;
    #1;
    checks++; if (Grant !== 2'b01) begin errors++; $display("FAIL v4_pre_flush got %b want 01", Grant); end
    nextCycle();
    checks++; if (Grant !== 2'b00 || MemoryBusCycle !== 1'b0 || M0Stall !== 1'b1) begin errors++;
      $display("FAIL v4_flush_state got grant=%b cyc=%b stall=%b want 00/0/1", Grant, MemoryBusCycle, M0Stall); end
    MemoryBusAcknowledge = 1; MemoryDataOut = 32'hCAFE_F00D;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if ({M0Acknowledge, M1Acknowledge} !== 2'b00 || M0DataOut !== 32'h0 || M1DataOut !== 32'h0) begin errors++;
        $display("FAIL v4_discard%0d got acks=%b d0=%h d1=%h want 00/0/0", i, {M0Acknowledge, M1Acknowledge}, M0DataOut, M1DataOut); end
      nextCycle();
    end
    MemoryBusAcknowledge = 0;
    #1;
    checks++; if (Grant !== 2'b00 || BusError !== 1'b0) begin errors++;
      $display("FAIL v4_drained got grant=%b err=%b want 00/0", Grant, BusError); end
    nextCycle();
    M0Cycle = 1;
    nextCycle();
    checks++; if (Grant !== 2'b01) begin errors++; $display("FAIL v4_back_to_idle got %b want 01", Grant); end
  endtask

  task automatic test_timeout();
    applyReset();
    M1Cycle = 1; M1Strobe = 1;
    nextCycle();
    nextCycle();
    M1Strobe = 0;
    for (int i = 0; i < TOUT; i++) begin
      #1;
      checks++; if (BusError !== 1'b0 || Grant !== 2'b10) begin errors++;
        $display("FAIL v5_wait%0d got err=%b grant=%b want 0/10", i, BusError, Grant); end
      nextCycle();
    end
    checks++; if (BusError !== 1'b1 || Grant !== 2'b00) begin errors++;
      $display("FAIL v5_pulse got err=%b grant=%b want 1/00", BusError, Grant); end
    M1Cycle = 0;
    nextCycle();
    checks++; if (BusError !== 1'b0 || Grant !== 2'b00) begin errors++;
      $display("FAIL v5_pulse_end got err=%b grant=%b want 0/00", BusError, Grant); end
  endtask

  task automatic test_reset_mid();
    applyReset();
    M1Cycle = 1; M1Strobe = 1; M1Address = 32'h300;
    nextCycle();
    nextCycle(); nextCycle(); nextCycle();
    Reset = 0;
    #1;
    checks++; if (Grant !== 2'b00 || M1Stall !== 1'b1 || M0Stall !== 1'b1 || MemoryBusStrobe !== 1'b0 || MemoryBusCycle !== 1'b0) begin errors++;
      $display("FAIL v6_async got grant=%b st=%b%b stb=%b cyc=%b want 00/11/0/0", Grant, M0Stall, M1Stall, MemoryBusStrobe, MemoryBusCycle); end
    nextCycle();
    Reset = 1; M1Strobe = 0; MemoryBusAcknowledge = 1;
    #1;
    checks++; if ({M0Acknowledge, M1Acknowledge} !== 2'b00 || Grant !== 2'b00) begin errors++;
      $display("FAIL v6_late_ack got acks=%b grant=%b want 00/00", {M0Acknowledge, M1Acknowledge}, Grant); end
    nextCycle();
    checks++; if (Grant !== 2'b10 || M1Acknowledge !== 1'b1) begin errors++;
      $display("FAIL v6_regrant got grant=%b ack=%b want 10/1", Grant, M1Acknowledge); end
    nextCycle();
    MemoryBusAcknowledge = 0; M1Strobe = 1;
    for (int i = 0; i < MAXOUT; i++) begin
      #1;
      checks++; if (M1Stall !== 1'b0) begin errors++; $display("FAIL v6_count%0d got stall=%b want 0", i, M1Stall); end
      nextCycle();
    end
    checks++; if (M1Stall !== 1'b1 || MemoryBusStrobe !== 1'b0) begin errors++;
      $display("FAIL v6_no_underflow got stall=%b stb=%b want 1/0", M1Stall, MemoryBusStrobe); end
  endtask

  task automatic test_random();
    logic [139:0] expV, gotV;
    applyReset();
    modelReset();
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 5) == 0) M0Cycle = ~M0Cycle;
      if ($urandom_range(0, 5) == 0) M1Cycle = ~M1Cycle;
      M0Strobe = $urandom_range(0, 1); M1Strobe = $urandom_range(0, 1);
      M0ReadWrite = $urandom_range(0, 1); M1ReadWrite = $urandom_range(0, 1);
      M0DataWidth = 2'($urandom_range(0, 3)); M1DataWidth = 2'($urandom_range(0, 3));
      M0Address = $urandom; M1Address = $urandom; M0DataIn = $urandom; M1DataIn = $urandom;
      MemoryDataOut = $urandom;
      MemoryBusAcknowledge = ($urandom_range(0, 2) == 0);
      MemoryBusStall = ($urandom_range(0, 3) == 0);
      #1;
      expV = modelOutputs();
      gotV = {Grant, BusError, M0Acknowledge, M0Stall, M0DataOut, M1Acknowledge, M1Stall, M1DataOut,
              MemoryBusCycle, MemoryBusStrobe, MemoryBusReadWrite, MemoryDataWidth, MemoryAddress, MemoryDataIn};
      checks++;
      if (gotV !== expV) begin
        errors++;
        $display("FAIL random_cycle%0d got %h want %h", n, gotV, expV);
      end
      modelStep();
      nextCycle();
    end
  endtask

  initial begin
    clearInputs();
    Reset = 0;
    #2;
    test_reset();
    test_single_read();
    test_handover();
    test_stall_limit();
    test_flush();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
